// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide (shift-add / restoring) with HI/LO result registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_bz;
    logic [WIDTH-1:0]   r_hi_out;
    logic [WIDTH-1:0]   r_lo_out;
    logic               r_dz;

    logic               w_accept;
    logic               w_last;
    logic               w_ge;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_msel;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dz;
    assign hi          = r_hi_out;
    assign lo          = r_lo_out;

    // Handshake: start is honoured whenever no iteration is in flight (IDLE or DONE)
    always_comb begin
        w_accept = start && (r_state != S_RUN);
        w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
        w_next   = w_accept ? S_RUN :
                   (r_state == S_RUN) ? (w_last ? S_DONE : S_RUN) : S_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // One iteration: multiply shifts the product right, divide shifts the remainder left
    always_comb begin
        w_a_mag  = (op[0] && a[WIDTH-1]) ? -a : a;
        w_b_mag  = (op[0] && b[WIDTH-1]) ? -b : b;
        w_sum    = r_hi + {1'b0, r_b};
        w_msel   = r_lo[0] ? w_sum : r_hi;
        w_shift  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
        w_diff   = w_shift - {1'b0, r_b};
        w_ge     = !w_diff[WIDTH];
        w_hi_n   = r_op[1] ? (w_ge ? w_diff : w_shift) : {1'b0, w_msel[WIDTH:1]};
        w_lo_n   = r_op[1] ? {r_lo[WIDTH-2:0], w_ge} : {w_msel[0], r_lo[WIDTH-1:1]};
        w_prod   = {w_hi_n[WIDTH-1:0], w_lo_n};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_q      = r_neg_q ? -w_lo_n : w_lo_n;
        w_r      = r_neg_r ? -w_hi_n[WIDTH-1:0] : w_hi_n[WIDTH-1:0];
    end

    // Datapath: latch magnitudes and sign flags on accept, iterate while running
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bz    <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= op;
            r_a     <= a;
            r_b     <= w_b_mag;
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_neg_q <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= op[0] && op[1] && a[WIDTH-1];
            r_bz    <= (b == '0);
        end else if (r_state == S_RUN) begin
            r_cnt   <= r_cnt + 1'b1;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
        end
    end

    // Result registers: written only on the final iteration, sign fix applied on the way in
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi_out <= '0;
            r_lo_out <= '0;
            r_dz     <= 1'b0;
        end else if (w_last) begin
            if (r_op[1]) begin
                r_hi_out <= r_bz ? r_a : w_r;
                r_lo_out <= r_bz ? '1 : w_q;
                r_dz     <= r_bz;
            end else begin
                {r_hi_out, r_lo_out} <= w_prod_s;
                r_dz                 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit against a plain-arithmetic reference
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    logic [64:0] sb_q[$];
    logic [64:0] last_exp = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: {div_by_zero, hi, lo} from integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint q;
        longint r;
        logic [63:0] p;
        case (o)
            2'd0: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
            2'd1: begin p = sx * sy; return {1'b0, p}; end
            2'd2: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got dz=%0b hi=%h lo=%h expected dz=%0b hi=%h lo=%h",
                     name, act[64], act[63:32], act[31:0], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset) last_exp = '0;
        else if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no done pulse", hi, lo);
            end else begin
                last_exp = sb_q.pop_front();
                check("result", {div_by_zero, hi, lo}, last_exp);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: busy=%0b expected 0", busy);
        end
        start = 1'b1; op = o; a = x; b = y;
        if (push) sb_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done=%0b expected 1", done);
        end
    endtask

    initial begin
        int cnt;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, div_by_zero, hi, lo}, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Busy length and done timing on the all-ones unsigned product
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 65'(cnt), 65'd32);
        check("done_after_busy", 65'(done), 65'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 65'(done), 65'd0);

        issue(2'd1, 32'hFFFF_FFFD, 32'd7, 1);
        wait_done();
        issue(2'd2, 32'd100, 32'd7, 1);
        wait_done();
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done();
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done();
        issue(2'd2, 32'h1234, 32'd0, 1);
        wait_done();
        issue(2'd0, 32'd2, 32'd3, 1);
        wait_done();
        @(posedge clk); #1;

        // Mid-run disturbance must be ignored, and HI/LO must hold the previous result
        issue(2'd3, 32'hFFFF_FF00, 32'd13, 1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_during_run", {div_by_zero, hi, lo}, last_exp);
        start = 1'b1; op = 2'd0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_after_disturb", {div_by_zero, hi, lo}, last_exp);
        wait_done();

        // Back-to-back start during the DONE cycle
        issue(2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1);
        check("b2b_busy", 65'(busy), 65'd1);
        wait_done();

        // Reset mid-divide aborts without a done pulse
        issue(2'd2, 32'hFFFF_0000, 32'd3, 0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_reset", {busy, done, div_by_zero, hi, lo}, '0);
        repeat (40) @(posedge clk);
        #1;
        issue(2'd0, 32'd5, 32'd5, 1);
        wait_done();

        // Randomized mix with corner operands, alternating gaps and back-to-back issue
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            issue(ro, ra, rb, 1);
            wait_done();
            if (i % 3 == 0) begin
                @(posedge clk); #1;
            end
        end

        cnt = 0;
        while (sb_q.size() != 0 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("scoreboard_drained", 65'(sb_q.size()), 65'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
